out_port_fifo: RTL and testbench

//   Output-port buffer downstream of the pipelined 8-bit CPU. It captures each
//   OUT-instruction write (out_we/out_data) into a small FIFO and drains it to an

---
 rtl/out_port_fifo.sv | 127 ++++++++++++
 tb/tb_out_port_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/out_port_fifo.sv
// out_port_fifo: output-port buffer between the CPU OUT instruction and an
// external consumer. Bytes written by the CPU are queued in a small FIFO and
// drained over a valid/ready handshake. O_Port mirrors the last accepted byte.
// out_stall asks the CPU to hold its OUT instruction while the FIFO is full.
// ovf records any write that arrived while the FIFO was full.
//
// Handshake: a byte moves to the consumer on every rising edge where
// ext_valid=1 and ext_ready=1. ext_valid/ext_data depend only on registers.
// While ext_valid=1 and ext_ready=0, ext_data holds its value. ext_ready is
// ignored when the FIFO is empty. On the CPU side, out_we is taken whenever
// out_stall=0. Otherwise the byte is dropped and flagged in ovf.
module out_port_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       out_we,
  input  logic [7:0] out_data,
  output logic       out_stall,
  output logic [7:0] O_Port,
  output logic [7:0] ext_data,
  output logic       ext_valid,
  input  logic       ext_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage and state registers.
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [7:0]    o_port_q, o_port_d;
  logic          ovf_q,    ovf_d;

  // Decoded status and transfer strobes.
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic overflow;

  // Status flags come only from the occupancy register.
  always_comb begin
    full  = (count_q == CNT_FULL);
    empty = (count_q == CNT_ZERO);
  end

  // A full FIFO rejects the write, even when a pop frees a slot in the same
  // cycle. This keeps out_stall a pure register decode.
  always_comb begin
    push     = out_we & ~full;
    overflow = out_we &  full;
    pop      = ~empty & ext_ready;
  end

  // Next-state logic for pointers, occupancy, the mirror port and the overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    o_port_d = o_port_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      o_port_d = out_data;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new overflow in the same cycle as ovf_clr must not be lost.
    if (overflow) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      o_port_q <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      o_port_q <= o_port_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data array has no reset. Stale entries are masked by the empty check on read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

  // First-word fall-through read port. Outputs depend on registers only.
  always_comb begin
    ext_valid = ~empty;
    ext_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    out_stall = full;
    O_Port    = o_port_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Testbench for out_port_fifo. The directed steps follow the intended usage.
// A randomized phase follows. A queue-based reference model predicts every output.
module tb_out_port_fifo;

  localparam int DEPTH = 4;

  // Clock and reset.
  logic       clk = 1'b0;
  logic       rstn;
  always #5 clk = ~clk;

  // DUT signals.
  logic       out_we;
  logic [7:0] out_data;
  logic       out_stall;
  logic [7:0] O_Port;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic       ovf;
  logic       ovf_clr;

  out_port_fifo #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .out_we    (out_we),
    .out_data  (out_data),
    .out_stall (out_stall),
    .O_Port    (O_Port),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Scoreboard state: expected FIFO contents, mirror port and overflow flag.
  logic [7:0] exp_q[$];
  logic [7:0] m_oport;
  logic       m_ovf;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model.
  task automatic check_all(input string tag);
    logic [7:0] e_data;
    e_data = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    chk({tag, ".ext_valid"}, {7'd0, ext_valid}, {7'd0, exp_q.size() != 0});
    chk({tag, ".ext_data"},  ext_data, e_data);
    chk({tag, ".out_stall"}, {7'd0, out_stall}, {7'd0, exp_q.size() == DEPTH});
    chk({tag, ".O_Port"},    O_Port, m_oport);
    chk({tag, ".ovf"},       {7'd0, ovf}, {7'd0, m_ovf});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_oport = 8'h00;
    m_ovf   = 1'b0;
  endtask

  // Model one clock edge from the inputs applied before it.
  task automatic model_edge(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
    bit was_full;
    was_full = (exp_q.size() == DEPTH);
    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (we && !was_full) begin
      exp_q.push_back(d);
      m_oport = d;
    end
    if (we && was_full) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
  endtask

  // Driver: starts and ends on a falling edge, with the check on the falling edge.
  task automatic cycle(input string tag, input logic we, input logic [7:0] d,
                       input logic rdy, input logic clr);
    out_we = we; out_data = d; ext_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_edge(we, d, rdy, clr);
    @(negedge clk);
    check_all(tag);
  endtask

  logic [7:0] head;

  initial begin
    rstn = 1'b0; out_we = 1'b0; out_data = 8'h00; ext_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    rstn = 1'b1;

    // 1: single push with the consumer stalled.
    cycle("t1_push", 1'b1, 8'hF0, 1'b0, 1'b0);
    chk("t1_data_lit", ext_data, 8'hF0);
    cycle("t1_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 2: fill the FIFO, then overflow.
    for (int i = 1; i <= 4; i++) cycle("t2_fill", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("t2_stall_lit", {7'd0, out_stall}, 8'h01);
    cycle("t2_ovf", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t2_oport_lit", O_Port, 8'hA4);
    chk("t2_ovf_lit", {7'd0, ovf}, 8'h01);

    // 3: drain, then clear the sticky flag.
    for (int i = 1; i <= 4; i++) begin
      chk("t3_seq", ext_data, 8'hA0 + 8'(i));
      cycle("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle("t3_idle", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_ovf_held", {7'd0, ovf}, 8'h01);
    cycle("t3_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // 4: steady push+pop at occupancy 2, wrapping the pointers.
    cycle("t4_pre", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("t4_pre", 1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle("t4_pp", 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    chk("t4_head_lit", ext_data, 8'hB4);
    for (int i = 0; i < 2; i++) cycle("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 5: asynchronous reset with bytes queued, checked before any edge.
    for (int i = 0; i < 3; i++) cycle("t5_fill", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    cycle("t5_ovfset", 1'b0, 8'h00, 1'b0, 1'b0);
    out_we = 1'b0; ext_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all("t5_async");
    @(negedge clk);
    rstn = 1'b1;
    check_all("t5_after");

    // 6: stalled consumer while pushing; the head must not move.
    cycle("t6_first", 1'b1, 8'hD0, 1'b0, 1'b0);
    head = 8'hD0;
    for (int i = 1; i <= 5; i++) begin
      cycle("t6_hold", 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
      chk("t6_stable", ext_data, head);
    end
    cycle("t6_ovfclr_race", 1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("t6_drain", 1'b0, 8'h00, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
